// File: rtl/cordic_vector_pkg.sv
// Constants shared with the cordicsine rotation path: Q15 angle scale, pi/2,
// the inverse CORDIC gain and the arctangent table.
package cordic_vector_pkg;

    localparam int FIX_SHIFT = 15;

    // pi/2 in Q15; the unsigned output angle spans [0, 4*PI2).
    localparam int PI2 = 32'h0000_C90F;

    // 1/1.64676 in Q15, used to strip the CORDIC gain from the magnitude.
    localparam logic [15:0] AG_CONST = 16'h4DBA;

    // atan(2^-i) in Q15, truncated; index 0 is the 45 degree step.
    localparam logic [0:15][15:0] ATAN_TABLE = {
        16'h6487, 16'h3B58, 16'h1F5B, 16'h0FEA,
        16'h07FD, 16'h03FF, 16'h01FF, 16'h00FF,
        16'h007F, 16'h003F, 16'h001F, 16'h000F,
        16'h0007, 16'h0003, 16'h0001, 16'h0000
    };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for the CORDIC micro-rotation index.
// Indices beyond the table return zero.
module cordic_atan_rom
    import cordic_vector_pkg::*;
#(
    parameter int AW = 18
) (
    input  logic [4:0]    ctr,
    output logic [AW-1:0] atan
);

    always_comb begin
        // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
        atan = '0;
        if (ctr < 5'd16) begin
            atan = AW'(ATAN_TABLE[ctr[3:0]]);
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative CORDIC vectoring engine: atan2 and magnitude of a signed (x,y) sample.
// Define CORDIC_MAG_COMP_EN to add the MAGCOMP state that removes the CORDIC gain from out_mag.
module cordic_vector
    import cordic_vector_pkg::*;
#(
    parameter int ITER = 16,
    parameter int DW   = 16,
    parameter int AW   = 18
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 update,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    output logic                 ready,
    output logic [AW-1:0]        out_angle,
    output logic [DW-1:0]        out_mag
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPUTE = 3'd1;
    localparam logic [2:0] S_FINISH  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd4;
`ifdef CORDIC_MAG_COMP_EN
    localparam logic [2:0] S_MAGCOMP = 3'd3;
    localparam int         PW        = AW + FIX_SHIFT + 1;
`endif

    localparam logic signed [AW:0] TWO_PI2  = (AW+1)'(2 * PI2);
    localparam logic signed [AW:0] FOUR_PI2 = (AW+1)'(4 * PI2);

    logic [2:0]           state;
    logic [4:0]           ctr;
    logic signed [AW-1:0] x, y;
    logic signed [AW:0]   z;
    logic                 folded;
    logic                 zero_in;
    logic [AW-1:0]        atan_val;

    logic signed [AW-1:0] cap_x, cap_y;
    logic signed [AW-1:0] x_shr, y_shr, x_step, y_step;
    logic signed [AW:0]   z_step, z_off, angle_sum, angle_wrap;

    cordic_atan_rom #(.AW(AW)) u_atan_rom (
        .ctr  (ctr),
        .atan (atan_val)
    );

    always_comb begin
        cap_x = AW'(in_x);
        cap_y = AW'(in_y);
        x_shr = x >>> ctr;
        y_shr = y >>> ctr;
        // Drive y toward zero; z accumulates the rotation applied.
        if (!y[AW-1]) begin
            x_step = x + y_shr;
            y_step = y - x_shr;
            z_step = z + $signed({1'b0, atan_val});
        end else begin
            x_step = x - y_shr;
            y_step = y + x_shr;
            z_step = z - $signed({1'b0, atan_val});
        end
        z_off      = folded ? TWO_PI2 : '0;
        angle_sum  = z_off + z;
        angle_wrap = angle_sum[AW] ? angle_sum + FOUR_PI2 : angle_sum;
    end

`ifdef CORDIC_MAG_COMP_EN
    logic [PW-1:0] acc, acc_next;
    logic [DW-1:0] mag_comp;

    // One bit of AG_CONST per cycle, LSB first.
    always_comb begin
        acc_next = acc + (AG_CONST[ctr[3:0]] ? (PW'($unsigned(x)) << ctr) : '0);
        mag_comp = (acc_next[PW-1:FIX_SHIFT+DW] != '0) ? '1 : acc_next[FIX_SHIFT +: DW];
    end
`else
    logic [DW-1:0] mag_raw;

    always_comb begin
        mag_raw = (x[AW-1:DW] != '0) ? '1 : x[DW-1:0];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ctr       <= '0;
            x         <= '0;
            y         <= '0;
            z         <= '0;
            folded    <= 1'b0;
            zero_in   <= 1'b0;
            ready     <= 1'b0;
            out_angle <= '0;
            out_mag   <= '0;
`ifdef CORDIC_MAG_COMP_EN
            acc       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (update) begin
                        // Fold the left half-plane onto the right; FINISH adds pi back.
                        x       <= in_x[DW-1] ? -cap_x : cap_x;
                        y       <= in_x[DW-1] ? -cap_y : cap_y;
                        folded  <= in_x[DW-1];
                        zero_in <= (in_x == '0) && (in_y == '0);
                        z       <= '0;
                        ctr     <= '0;
                        ready   <= 1'b0;
                        state   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    x <= x_step;
                    y <= y_step;
                    z <= z_step;
                    if (ctr == 5'(ITER-1)) begin
                        ctr   <= '0;
                        state <= S_FINISH;
                    end else begin
                        ctr <= ctr + 5'd1;
                    end
                end
                S_FINISH: begin
                    out_angle <= zero_in ? '0 : angle_wrap[AW-1:0];
`ifdef CORDIC_MAG_COMP_EN
                    acc   <= '0;
                    ctr   <= '0;
                    state <= S_MAGCOMP;
`else
                    out_mag <= zero_in ? '0 : mag_raw;
                    ready   <= 1'b1;
                    state   <= S_DONE;
`endif
                end
`ifdef CORDIC_MAG_COMP_EN
                S_MAGCOMP: begin
                    acc <= acc_next;
                    if (ctr == 5'd15) begin
                        out_mag <= zero_in ? '0 : mag_comp;
                        ctr     <= '0;
                        ready   <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        ctr <= ctr + 5'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed vector table, protocol sequences
// and random samples against an ideal atan2/magnitude model.
`timescale 1ns/1ps
module tb_cordic_vector;

    localparam int DW   = 16;
    localparam int AW   = 18;
    localparam int ITER = 16;
`ifdef CORDIC_MAG_COMP_EN
    localparam int LAT        = 2*ITER + 1;
    localparam bit MAG_EN     = 1'b1;
`else
    localparam int LAT        = ITER + 1;
    localparam bit MAG_EN     = 1'b0;
`endif
    localparam longint FULL   = 205884;          // 4 * 0xC90F
    localparam real    K_GAIN = 1.6467602581210654;
    localparam real    M_PI   = 3.141592653589793;
    localparam longint ANG_TOL     = 6;
    localparam longint MAG_TOL     = MAG_EN ? 2 : 8;
    // Random samples: truncated atan table entries can add up when late steps share a sign.
    localparam longint ANG_TOL_RND = 20;
    localparam longint MAG_TOL_RND = MAG_EN ? 8 : 16;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 update = 1'b0;
    logic signed [DW-1:0] in_x = '0;
    logic signed [DW-1:0] in_y = '0;
    logic                 ready;
    logic [AW-1:0]        out_angle;
    logic [DW-1:0]        out_mag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        longint             angle;
        longint             mag_raw;
        longint             mag_en;
    } vec_t;

    vec_t vecs[8];

    cordic_vector #(.ITER(ITER), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .update    (update),
        .in_x      (in_x),
        .in_y      (in_y),
        .ready     (ready),
        .out_angle (out_angle),
        .out_mag   (out_mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint actual, input longint expected,
                         input longint tol, input bit circular);
        longint d;
        checks++;
        d = actual - expected;
        if (d < 0) d = -d;
        if (circular && d > FULL/2) begin
            d = FULL - d;
            if (d < 0) d = -d;
        end
        if (d > tol) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) +/-%0d",
                     name, actual, actual, expected, expected, tol);
        end
    endtask

    function automatic longint ideal_angle(input int vx, input int vy);
        real a;
        a = $atan2(real'(vy), real'(vx));
        if (a < 0.0) a = a + 2.0 * M_PI;
        return longint'(a * 32768.0);
    endfunction

    function automatic longint ideal_mag(input int vx, input int vy);
        real m;
        longint r;
        m = $sqrt(real'(vx) * real'(vx) + real'(vy) * real'(vy));
        r = MAG_EN ? longint'(m) : longint'(m * K_GAIN);
        return (r > 65535) ? 65535 : r;
    endfunction

    // Pulse update for one clock; returns at the negedge after the capture edge.
    task automatic start(input logic signed [15:0] vx, input logic signed [15:0] vy);
        @(negedge clk);
        in_x   = vx;
        in_y   = vy;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_vec(input string name, input logic signed [15:0] vx, input logic signed [15:0] vy,
                           input longint exp_angle, input longint exp_mag,
                           input longint a_tol, input longint m_tol);
        int n;
        start(vx, vy);
        wait_ready(n);
        check({name, "_latency"}, n, LAT, 0, 1'b0);
        check({name, "_angle"}, longint'(out_angle), exp_angle, a_tol, 1'b1);
        check({name, "_mag"}, longint'(out_mag), exp_mag, m_tol, 1'b0);
    endtask

    initial begin
        int n;
        logic signed [15:0] rx, ry;
        int ax, ay;

        vecs[0] = '{16'sd16384,  16'sd0,      64'h00000, 26981, 16384};
        vecs[1] = '{16'sd0,      16'sd16384,  64'h0C90F, 26981, 16384};
        vecs[2] = '{-16'sd16384, 16'sd0,      64'h1921E, 26981, 16384};
        vecs[3] = '{16'sd0,      -16'sd16384, 64'h25B2D, 26981, 16384};
        vecs[4] = '{16'sd11585,  16'sd11585,  64'h06487, 26980, 16384};
        vecs[5] = '{16'sd11585,  -16'sd11585, 64'h2BFB5, 26980, 16384};
        vecs[6] = '{-16'sd32768, -16'sd32768, 64'h1F6A5, 65535, 46341};
        vecs[7] = '{16'sd0,      16'sd0,      64'h00000, 0,     0};

        #2;
        check("reset_ready", longint'(ready), 0, 0, 1'b0);
        check("reset_angle", longint'(out_angle), 0, 0, 1'b0);
        check("reset_mag", longint'(out_mag), 0, 0, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Directed table; the (0,0) entry must be exact.
        for (int i = 0; i < 8; i++) begin
            bit is_zero;
            is_zero = (vecs[i].x == 0) && (vecs[i].y == 0);
            run_vec($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].angle,
                    MAG_EN ? vecs[i].mag_en : vecs[i].mag_raw,
                    is_zero ? 0 : ANG_TOL, is_zero ? 0 : MAG_TOL);
        end

        // update pulsed mid-computation with different inputs is ignored.
        @(negedge clk);
        in_x = 16'sd0;
        in_y = 16'sd16384;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        n = 0;
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
            update = (n == 5);
            if (n == 5) begin
                in_x = -16'sd16384;
                in_y = 16'sd0;
            end
        end
        update = 1'b0;
        check("ignore_latency", n, LAT, 0, 1'b0);
        check("ignore_angle", longint'(out_angle), 64'h0C90F, ANG_TOL, 1'b1);

        // update held high in DONE gives back-to-back computations.
        @(negedge clk);
        in_x = 16'sd0;
        in_y = -16'sd16384;
        update = 1'b1;
        @(negedge clk);
        check("b2b_drop", longint'(ready), 0, 0, 1'b0);
        wait_ready(n);
        check("b2b_latency1", n, LAT, 0, 1'b0);
        check("b2b_angle1", longint'(out_angle), 64'h25B2D, ANG_TOL, 1'b1);
        @(negedge clk);
        update = 1'b0;
        check("b2b_redrop", longint'(ready), 0, 0, 1'b0);
        check("b2b_hold_angle", longint'(out_angle), 64'h25B2D, ANG_TOL, 1'b1);
        wait_ready(n);
        check("b2b_latency2", n, LAT, 0, 1'b0);
        check("b2b_angle2", longint'(out_angle), 64'h25B2D, ANG_TOL, 1'b1);

        // Reset asserted at ctr=8 aborts to reset values; the engine stays idle afterwards.
        start(16'sd11585, 16'sd11585);
        repeat (8) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_ready", longint'(ready), 0, 0, 1'b0);
        check("abort_angle", longint'(out_angle), 0, 0, 1'b0);
        check("abort_mag", longint'(out_mag), 0, 0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_resume", longint'(ready), 0, 0, 1'b0);
        run_vec("after_abort", -16'sd16384, 16'sd0, 64'h1921E,
                MAG_EN ? 16384 : 26981, ANG_TOL, MAG_TOL);

        // Random samples against the ideal model; tiny vectors are skipped
        // because their angle is dominated by input quantisation.
        for (int i = 0; i < 40; i++) begin
            do begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                ax = (rx < 0) ? -int'(rx) : int'(rx);
                ay = (ry < 0) ? -int'(ry) : int'(ry);
            end while (ax < 4096 && ay < 4096);
            run_vec($sformatf("rnd%0d(%0d,%0d)", i, rx, ry), rx, ry,
                    ideal_angle(int'(rx), int'(ry)), ideal_mag(int'(rx), int'(ry)),
                    ANG_TOL_RND, MAG_TOL_RND);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
